fifo_sync_ctrl: RTL and testbench
=================================

Name: fifo_sync_ctrl

Overview:
Parametrised synchronous single-clock FIFO that generalises the existing fifo block. It adds:
- a first-word-fall-through (FWFT) read mode;
- an occupancy count output;
- programmable almost-full and almost-empty thresholds;
- a synchronous flush;
- sticky overflow/underflow error flags.

It is the standard buffering element between streaming producers and consumers in the datapath.

Parameters:
DEPTH, 8, number of entries; power of two, >= 2
WIDTH, 8, data word width in bits
FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; range 1..DEPTH
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH; range 0..DEPTH-1

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
wen  in  1  write request
ren  in  1  read request
flush  in  1  synchronous clear of FIFO contents
err_clr  in  1  synchronous clear of sticky error flags
data_in  in  WIDTH  write data
data_out  out  WIDTH  read data
data_valid  out  1  data_out holds a valid word (mode-dependent, see Behaviour)
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Reset (rst_n=0, async): pointers = 0, count = 0, data_out = 0, data_valid = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0. Memory contents are don't-care.
- Pointers: read and write pointers are $clog2(DEPTH)+1 bits; the MSB distinguishes wrap.
  - full when the addresses are equal and the MSBs differ; empty when the pointers are equal.
  - Wrap from DEPTH-1 to 0 is seamless.
- Write accept: wr_ok = wen & ~full & ~flush. On wr_ok, mem[wptr] <= data_in and wptr increments.
- Write rejection: wen & full (flush=0) drops the word, sets overflow, leaves state unchanged. This holds even if ren is accepted in the same cycle; there is no write-through-when-full.
- Read accept: rd_ok = ren & ~empty & ~flush; rptr increments.
- Read rejection: ren & empty (flush=0) sets underflow and leaves state unchanged. This holds even if wen is accepted in the same cycle.
- Simultaneous wr_ok & rd_ok: count unchanged, both pointers advance.
- Count: +1 on wr_ok only, -1 on rd_ok only. All status flags derive from the registered count/pointers, so they reflect state after the last edge.
- FWFT=0 (standard mode):
  - On rd_ok, data_out <= mem[rptr] and data_valid <= 1 on the next edge.
  - data_valid is a 1-cycle pulse per accepted read; read latency is 1 cycle.
  - data_out holds its last value when no read occurs.
- FWFT=1:
  - data_out = mem[rptr] combinationally; data_valid = ~empty.
  - ren acts as a pop/acknowledge of the presented word.
  - A write into an empty FIFO becomes visible (data_valid=1) the cycle after the write edge.
- Flush:
  - Flush takes priority over wen/ren in the same cycle: pointers = 0, count = 0, data_valid = 0, and the empty/almost_empty flags set.
  - overflow/underflow are not affected by flush, and flush never sets them.
  - data_out holds its value in FWFT=0 and is don't-care in FWFT=1.
- err_clr clears overflow/underflow. If an error event occurs in the same cycle as err_clr, the flag is set (set wins).
- Reset mid-operation: immediate async return to reset state. In-flight data is lost.

Test Plan:
1. DEPTH=8, WIDTH=8, FWFT=0. Write 0xAA, idle 5 cycles, then pulse ren 1 cycle.
   -> data_out=0xAA with data_valid=1 for exactly 1 cycle, one cycle after the ren edge; count goes 1->0; empty=1.
2. Write 0x01..0x08 on consecutive cycles.
   -> full=1 and count=8 after the 8th edge; almost_full=1 from count=6.
   -> A 9th write of 0x09 sets overflow=1 with count still 8.
   -> Reading all 8 returns 0x01..0x08 in order.
3. Wrap test: repeat 3 rounds of 5 writes followed by 5 reads.
   -> Data stays in order across pointer wrap; count returns to 0 and empty=1 after each round.
4. From count=4, assert wen and ren for 4 cycles.
   -> count stays 4 and output order is preserved.
   -> With the FIFO empty, assert ren & wen together: underflow=1, the write is accepted, count=1.
5. FWFT=1: write 0x5C into the empty FIFO.
   -> The next cycle shows data_out=0x5C, data_valid=1 with no ren.
   -> Pulsing ren gives data_valid=0 and empty=1 on the next cycle.
6. Fill to count=5, then assert flush together with wen=1.
   -> Next cycle: count=0, empty=1, data_valid=0, no write accepted, overflow/underflow unchanged.
   -> Assert rst_n=0 mid-burst: all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_sync_ctrl.sv
// rtl/fifo_sync_ctrl.sv - single-clock FIFO with FWFT option, occupancy count,
// programmable almost thresholds, synchronous flush and sticky error flags.
module fifo_sync_ctrl #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 8,
  parameter bit FWFT      = 1'b0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wen,
  input  logic                   ren,
  input  logic                   flush,
  input  logic                   err_clr,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH-1:0]       data_out,
  output logic                   data_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_ONE = (AW+1)'(1);
  localparam logic [AW:0] L_AF  = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] L_AE  = (AW+1)'(AE_THRESH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_rd_ok;
  logic w_wr_rej;
  logic w_rd_rej;

  // Extra pointer MSB separates "same slot, full" from "same slot, empty".
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty  = (r_wptr == r_rptr);
  assign w_wr_ok  = wen & ~w_full  & ~flush;
  assign w_rd_ok  = ren & ~w_empty & ~flush;
  assign w_wr_rej = wen &  w_full  & ~flush;
  assign w_rd_rej = ren &  w_empty & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + L_ONE;
      if (w_rd_ok) r_rptr <= r_rptr + L_ONE;
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + L_ONE;
        2'b01:   r_count <= r_count - L_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wptr[AW-1:0]] <= data_in;
  end

  // A new error event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_wr_rej | (r_overflow  & ~err_clr);
      r_underflow <= w_rd_rej | (r_underflow & ~err_clr);
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign data_out   = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
      assign data_valid = ~w_empty;
    end else begin : g_std
      logic [WIDTH-1:0] r_data_out;
      logic             r_data_valid;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_data_out   <= '0;
          r_data_valid <= 1'b0;
        end else begin
          r_data_valid <= w_rd_ok;
          if (w_rd_ok) r_data_out <= r_mem[r_rptr[AW-1:0]];
        end
      end

      assign data_out   = r_data_out;
      assign data_valid = r_data_valid;
    end
  endgenerate

  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = r_count;
  assign almost_full  = (r_count >= L_AF);
  assign almost_empty = (r_count <= L_AE);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// tb/tb_fifo_sync_ctrl.sv - randomized and directed bench for fifo_sync_ctrl
// in both read modes, checked against a queue-based reference model.
module tb_fifo_sync_ctrl;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wen = 1'b0, ren = 1'b0, flush = 1'b0, err_clr = 1'b0;
  logic [WIDTH-1:0] data_in = '0;

  logic [WIDTH-1:0] s_dout, f_dout;
  logic             s_dv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic             f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [3:0]       s_count, f_count;

  fifo_sync_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(1'b0)) u_std (
    .clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren), .flush(flush), .err_clr(err_clr),
    .data_in(data_in), .data_out(s_dout), .data_valid(s_dv), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
  );

  fifo_sync_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren), .flush(flush), .err_clr(err_clr),
    .data_in(data_in), .data_out(f_dout), .data_valid(f_dv), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_cyc    = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_dv, m_ovf, m_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=0x%0h exp=0x%0h", tag, n_cyc, got, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_dv   = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic model_step(input logic w, input logic r, input logic f, input logic ec,
                            input logic [WIDTH-1:0] d);
    bit was_full, was_empty, ovf_ev, unf_ev;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    ovf_ev = !f && w && was_full;
    unf_ev = !f && r && was_empty;
    if (f) begin
      q.delete();
      m_dv = 1'b0;
    end else begin
      m_dv = r && !was_empty;
      if (m_dv) m_dout = q.pop_front();
      if (w && !was_full) q.push_back(d);
    end
    m_ovf = ovf_ev ? 1'b1 : (ec ? 1'b0 : m_ovf);
    m_unf = unf_ev ? 1'b1 : (ec ? 1'b0 : m_unf);
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check("std_count", 32'(s_count), n);
    check("std_full",  32'(s_full),  32'(n == DEPTH));
    check("std_empty", 32'(s_empty), 32'(n == 0));
    check("std_af",    32'(s_af),    32'(n >= AF));
    check("std_ae",    32'(s_ae),    32'(n <= AE));
    check("std_ovf",   32'(s_ovf),   32'(m_ovf));
    check("std_unf",   32'(s_unf),   32'(m_unf));
    check("std_dv",    32'(s_dv),    32'(m_dv));
    check("std_dout",  32'(s_dout),  32'(m_dout));
    check("fwft_count", 32'(f_count), n);
    check("fwft_ovf",  32'(f_ovf),   32'(m_ovf));
    check("fwft_unf",  32'(f_unf),   32'(m_unf));
    check("fwft_dv",   32'(f_dv),    32'(n != 0));
    if (n != 0) check("fwft_dout", 32'(f_dout), 32'(q[0]));
  endtask

  task automatic cyc(input logic w, input logic r, input logic f, input logic ec,
                     input logic [WIDTH-1:0] d);
    wen = w; ren = r; flush = f; err_clr = ec; data_in = d;
    @(posedge clk);
    n_cyc++;
    model_step(w, r, f, ec, d);
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    wen = 1'b0; ren = 1'b0; flush = 1'b0; err_clr = 1'b0;
    #1;
    model_reset();
    check_all();
    check("rst_std_dout", 32'(s_dout), 32'h0);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // registered read with idle gap
    cyc(1, 0, 0, 0, 8'hAA);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 8'h00);
    check("pulse_dout", 32'(s_dout), 32'hAA);
    cyc(0, 0, 0, 0, 8'h00);
    check("pulse_gone", 32'(s_dv), 32'h0);

    // fill, overflow, drain
    for (int i = 1; i <= 8; i++) cyc(1, 0, 0, 0, 8'(i));
    check("full_at_8", 32'(s_full), 32'h1);
    cyc(1, 0, 0, 0, 8'h09);
    check("ovf_set", 32'(s_ovf), 32'h1);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 8'h00);
    cyc(0, 0, 0, 1, 8'h00);

    // pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 8'(8'h10 * r + i));
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 8'h00);
    end

    // steady-state simultaneous read/write, then read+write on empty
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 8'(8'h40 + i));
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 8'(8'h50 + i));
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 8'h00);
    cyc(1, 1, 0, 0, 8'h77);
    check("unf_wr_acc", 32'(s_unf), 32'h1);
    cyc(0, 1, 0, 0, 8'h00);

    // error flag set beats clear in the same cycle
    cyc(0, 1, 0, 1, 8'h00);
    check("unf_set_wins", 32'(s_unf), 32'h1);
    cyc(0, 0, 0, 1, 8'h00);

    // fall-through presentation
    cyc(1, 0, 0, 0, 8'h5C);
    check("fwft_show", 32'(f_dout), 32'h5C);
    cyc(0, 1, 0, 0, 8'h00);
    check("fwft_pop_empty", 32'(f_empty), 32'h1);

    // flush wins over write; then reset mid-burst
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 8'(8'hC0 + i));
    cyc(1, 0, 1, 0, 8'hEE);
    check("flush_empty", 32'(s_empty), 32'h1);
    for (int i = 0; i < 3; i++) cyc(1, i[0], 0, 0, 8'(8'hD0 + i));
    cyc(1, 0, 0, 0, 8'hD9);
    async_reset();

    // randomized traffic with shifting write/read bias
    for (int blk = 0; blk < 4; blk++) begin
      int pw, pr;
      pw = (blk == 0) ? 75 : (blk == 1) ? 25 : 55;
      pr = (blk == 0) ? 25 : (blk == 1) ? 75 : 50;
      for (int i = 0; i < 120; i++) begin
        logic w, r, f, ec;
        w  = ($urandom_range(0, 99) < pw);
        r  = ($urandom_range(0, 99) < pr);
        f  = ($urandom_range(0, 99) < 2);
        ec = ($urandom_range(0, 99) < 5);
        cyc(w, r, f, ec, 8'($urandom));
      end
      if (blk == 2) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
